// File: rtl/msi_irq_pkg.sv
// msi_irq_pkg: shared FSM state type and vector-width helper for the MSI arbiter.
package msi_irq_pkg;

    typedef enum logic {IDLE, REQ} state_t;

    function automatic int vec_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/msi_irq_arbiter_rr_select.sv
// rr_select: combinational round-robin pick, searching from i_last+1 and wrapping at N-1.
module rr_select #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_idx,
    output logic         o_valid
);

    int w_pos;

    always_comb begin
        o_idx   = '0;
        o_valid = |i_req;
        w_pos   = 0;
        // Walk furthest-first so the nearest candidate after i_last wins.
        for (int k = N; k >= 1; k--) begin
            w_pos = (int'(i_last) + k) % N;
            if (i_req[w_pos[W-1:0]]) o_idx = w_pos[W-1:0];
        end
    end

endmodule

// File: rtl/msi_irq_arbiter.sv
// msi_irq_arbiter: latches interrupt events as pending bits and arbitrates them
// round-robin into a single MSI request/grant handshake.
module msi_irq_arbiter
    import msi_irq_pkg::*;
#(
    parameter int N_IRQ        = 4,
    parameter bit LEVEL_MODE   = 0,
    parameter bit MULTI_VECTOR = 1,
    localparam int VW          = vec_w(N_IRQ)
) (
    input  logic             axi_clk_pcie,
    input  logic             sys_resetn,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic [N_IRQ-1:0] irq_mask_i,
    input  logic             msi_enabled,
    input  logic             msi_grant,
    output logic             msi_request,
    output logic [VW-1:0]    msi_vector_o,
    output logic [N_IRQ-1:0] pending_o,
    output logic [N_IRQ-1:0] coalesced_o,
    input  logic [N_IRQ-1:0] coalesced_clr_i
);

    state_t             r_state;
    state_t             w_next;
    logic [N_IRQ-1:0]   r_irq_p;
    logic [N_IRQ-1:0]   r_armed;
    logic [N_IRQ-1:0]   r_pend;
    logic [N_IRQ-1:0]   r_coal;
    logic [N_IRQ-1:0]   r_req_mask;
    logic [VW-1:0]      r_sel;
    logic [VW-1:0]      r_last;
    logic [N_IRQ-1:0]   w_elig;
    logic [N_IRQ-1:0]   w_clr;
    logic [N_IRQ-1:0]   w_ev;
    logic [VW-1:0]      w_rr_idx;
    logic               w_rr_valid;

    rr_select #(.N(N_IRQ), .W(VW)) u_rr (
        .i_req   (w_elig),
        .i_last  (r_last),
        .o_idx   (w_rr_idx),
        .o_valid (w_rr_valid)
    );

    // A level source being granted this cycle is disarmed, so it must not re-pend on the same cycle.
    always_comb begin
        w_elig = r_pend & ~irq_mask_i;
        w_clr  = '0;
        if (r_state == REQ && msi_grant)
            w_clr = MULTI_VECTOR ? (N_IRQ'(1) << r_sel) : r_req_mask;
        w_ev = LEVEL_MODE ? (irq_i & r_armed & ~w_clr) : (irq_i & ~r_irq_p);
    end

    always_ff @(posedge axi_clk_pcie) begin
        if (!sys_resetn) r_state <= IDLE;
        else             r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? ((msi_enabled && w_rr_valid) ? REQ : IDLE)
                                   : (msi_grant ? IDLE : REQ);
    end

    always_comb begin
        msi_request  = (r_state == REQ);
        msi_vector_o = (msi_request && MULTI_VECTOR) ? r_sel : '0;
        pending_o    = r_pend;
        coalesced_o  = r_coal;
    end

    always_ff @(posedge axi_clk_pcie) begin
        if (!sys_resetn) begin
            r_irq_p    <= '0;
            r_armed    <= '1;
            r_pend     <= '0;
            r_coal     <= '0;
            r_req_mask <= '0;
            r_sel      <= '0;
            r_last     <= VW'(N_IRQ - 1);
        end else begin
            r_irq_p <= irq_i;
            r_armed <= LEVEL_MODE ? ((r_armed & ~w_clr) | ~irq_i) : '1;
            r_pend  <= (r_pend & ~w_clr) | w_ev;
            r_coal  <= (r_coal & ~coalesced_clr_i) | (w_ev & r_pend);
            if (r_state == IDLE && w_next == REQ) begin
                r_sel      <= w_rr_idx;
                r_req_mask <= w_elig;
            end
            if (r_state == REQ && msi_grant) r_last <= r_sel;
        end
    end

endmodule
